// File: rtl/axis_gated_packetizer.sv
// Gated AXI4-Stream packetizer: forwards gated samples as fixed-length
// packets, zero-padding any packet cut short by the gate falling.
module axis_gated_packetizer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        trg_flag,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic                        sts_overflow,
  output logic [31:0]                 sts_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    FLUSH
  } state_t;

  state_t                      state, state_nxt;
  logic [CNTR_WIDTH-1:0]       len_reg, len_nxt;
  logic [CNTR_WIDTH-1:0]       cntr, cntr_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] load_data;
  logic                        slot_free;
  logic                        at_last;
  logic                        load;
  logic                        ovf_set;

  assign s_axis_tready = 1'b1;
  assign slot_free     = ~m_axis_tvalid | m_axis_tready;
  assign at_last       = (cntr == len_reg);

  always_comb begin
    state_nxt = state;
    len_nxt   = len_reg;
    cntr_nxt  = cntr;
    load      = 1'b0;
    load_data = '0;
    ovf_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (trg_flag) begin
          state_nxt = PASS;
          len_nxt   = cfg_data;
          cntr_nxt  = '0;
        end
      end
      PASS: begin
        if (trg_flag) begin
          if (s_axis_tvalid) begin
            if (slot_free) begin
              load      = 1'b1;
              load_data = s_axis_tdata;
              cntr_nxt  = at_last ? '0 : cntr + 1'b1;
              if (at_last) len_nxt = cfg_data;
            end else begin
              ovf_set = 1'b1;
            end
          end
        end else begin
          state_nxt = (cntr == '0) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        // Pad the interrupted packet with zero beats up to its length
        if (slot_free) begin
          load     = 1'b1;
          cntr_nxt = at_last ? '0 : cntr + 1'b1;
          if (at_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      len_reg       <= '0;
      cntr          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sts_overflow  <= 1'b0;
      sts_data      <= '0;
    end else begin
      state   <= state_nxt;
      len_reg <= len_nxt;
      cntr    <= cntr_nxt;
      if (slot_free) begin
        m_axis_tvalid <= load;
        m_axis_tlast  <= load & at_last;
        if (load) m_axis_tdata <= load_data;
      end
      if (ovf_set) sts_overflow <= 1'b1;
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast)
        sts_data <= sts_data + 32'd1;
    end
  end

endmodule
